// File: rtl/dcache_ctrl_fsm.sv
// Control FSM for the set-associative data cache.
// Handles dirty-victim writeback and refill bursts, a frame-by-frame flush on
// halt, the final hit-count store and the sticky halt handshake.
module dcache_ctrl_fsm #(
  parameter int WORDS = 2,
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  localparam int OW = $clog2(WORDS),
  localparam int SW = $clog2(SETS),
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          dmemREN_i,
  input  logic          dmemWEN_i,
  input  logic          dhit_i,
  input  logic          victim_dirty_i,
  input  logic          frame_dirty_i,
  input  logic          flush_i,
  input  logic          dwait_i,
  output logic          dREN_o,
  output logic          dWEN_o,
  output logic [OW-1:0] word_off_o,
  output logic          wb_sel_o,
  output logic          fill_en_o,
  output logic          invalidate_o,
  output logic [SW-1:0] flush_set_o,
  output logic [WW-1:0] flush_way_o,
  output logic          flush_clean_o,
  output logic          hit_ct_en_o,
  output logic          hit_ct_store_o,
  output logic          busy_o,
  output logic          halt_o
);

  typedef enum logic [2:0] {
    IDLE, WB, FILL, FLSCAN, FLWB, CTSTORE, HALT
  } state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] set_q, set_d;
  logic [WW-1:0] way_q, way_d;
  logic          retry_q, retry_d;
  logic          dren_q, dwen_q, wb_sel_q, store_q, busy_q, halt_q;

  logic req, last_beat, last_frame;

  assign req        = dmemREN_i | dmemWEN_i;
  assign last_beat  = (cnt_q == OW'(WORDS - 1)) & ~dwait_i;
  assign last_frame = (set_q == SW'(SETS - 1)) && (way_q == WW'(WAYS - 1));

  // Next-state, beat/pointer bookkeeping and the input-dependent strobes.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    set_d         = set_q;
    way_d         = way_q;
    retry_d       = retry_q;
    fill_en_o     = 1'b0;
    invalidate_o  = 1'b0;
    flush_clean_o = 1'b0;
    hit_ct_en_o   = 1'b0;

    // Beats only advance in the burst states, and only when memory accepts.
    if ((state_q == WB || state_q == FILL || state_q == FLWB) && !dwait_i)
      cnt_d = cnt_q + OW'(1);

    case (state_q)
      IDLE: begin
        // The replayed access right after a refill must not count as a hit.
        retry_d     = 1'b0;
        hit_ct_en_o = req & dhit_i & ~retry_q;
        if (req && !dhit_i)
          state_d = victim_dirty_i ? WB : FILL;
        else if (flush_i)
          state_d = FLSCAN;
      end
      WB: begin
        if (last_beat) begin
          invalidate_o = 1'b1;
          state_d      = FILL;
        end
      end
      FILL: begin
        fill_en_o = ~dwait_i;
        if (last_beat) begin
          retry_d = 1'b1;
          state_d = IDLE;
        end
      end
      FLSCAN: begin
        if (frame_dirty_i)
          state_d = FLWB;
        else if (last_frame)
          state_d = CTSTORE;
        else if (set_q == SW'(SETS - 1)) begin
          set_d = '0;
          way_d = way_q + WW'(1);
        end else
          set_d = set_q + SW'(1);
      end
      FLWB: begin
        if (last_beat) begin
          flush_clean_o = 1'b1;
          if (last_frame)
            state_d = CTSTORE;
          else begin
            state_d = FLSCAN;
            if (set_q == SW'(SETS - 1)) begin
              set_d = '0;
              way_d = way_q + WW'(1);
            end else
              set_d = set_q + SW'(1);
          end
        end
      end
      CTSTORE: begin
        if (!dwait_i)
          state_d = HALT;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State registers plus the state-decoded outputs, registered from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      set_q    <= '0;
      way_q    <= '0;
      retry_q  <= 1'b0;
      dren_q   <= 1'b0;
      dwen_q   <= 1'b0;
      wb_sel_q <= 1'b0;
      store_q  <= 1'b0;
      busy_q   <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      set_q    <= set_d;
      way_q    <= way_d;
      retry_q  <= retry_d;
      dren_q   <= (state_d == FILL);
      dwen_q   <= (state_d == WB) || (state_d == FLWB) || (state_d == CTSTORE);
      wb_sel_q <= (state_d == WB) || (state_d == FLWB);
      store_q  <= (state_d == CTSTORE);
      busy_q   <= !((state_d == IDLE) || (state_d == HALT));
      halt_q   <= (state_d == HALT);
    end
  end

  assign dREN_o         = dren_q;
  assign dWEN_o         = dwen_q;
  assign wb_sel_o       = wb_sel_q;
  assign hit_ct_store_o = store_q;
  assign busy_o         = busy_q;
  assign halt_o         = halt_q;
  assign word_off_o     = cnt_q;
  assign flush_set_o    = set_q;
  assign flush_way_o    = way_q;

endmodule
